// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [DATA_W_DEF-1:0] HALT_INST = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {instruction, pc} pairs; head is presented combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head_data,
    output logic [ADDR_W-1:0] o_head_pc
);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop & (r_count != '0);
    // A pop in the same cycle frees the slot, so push into a full queue is legal then.
    assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_pc[r_wr_ptr]   <= i_push_pc;
        end
    end

    assign o_count     = r_count;
    assign o_valid     = (r_count != '0);
    assign o_head_data = o_valid ? r_data[r_rd_ptr] : '0;
    assign o_head_pc   = o_valid ? r_pc[r_rd_ptr] : '0;

    assert property (@(posedge clk) disable iff (rst) !(i_push && !w_push));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: RAM address issue, latency pipe, prefetch queue, jump redirect.
// Optional FETCH_HALT_EN: stop issuing after HALT_INST is fetched until jump or rst.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned QDEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [ADDR_W-1:0] o_fetch_pc,
    output logic              o_busy
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 2;

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_epoch;
    logic [MEM_LAT-1:0] r_pipe_vld;
    logic [MEM_LAT-1:0] r_pipe_ep;
    logic [ADDR_W-1:0] r_pipe_pc [MEM_LAT];

    logic [CNT_W-1:0]  w_q_count;
    logic [OCC_W-1:0]  w_inflight;
    logic [OCC_W-1:0]  w_occupancy;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_halted;
    logic              w_halt_push;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(r_pipe_vld[i]);
        end
    end

    assign w_pop       = o_inst_valid & i_inst_ready;
    // Words from before the last redirect carry a stale epoch and are dropped; jump also flushes.
    assign w_push      = r_pipe_vld[MEM_LAT-1] & (r_pipe_ep[MEM_LAT-1] == r_epoch) & ~i_jump;
    assign w_occupancy = OCC_W'(w_q_count) + w_inflight - OCC_W'(w_pop);
    assign w_issue     = (r_state == StRun) & i_en & ~i_jump & ~w_halted & ~w_halt_push
                       & (w_occupancy < OCC_W'(QDEPTH));

`ifdef FETCH_HALT_EN
    logic r_halted;

    assign w_halt_push = w_push & (i_mem_q == DATA_W'(HALT_INST));
    assign w_halted    = r_halted;

    always_ff @(posedge clk) begin
        if (rst || i_jump) r_halted <= 1'b0;
        else if (w_halt_push) r_halted <= 1'b1;
    end
`else
    assign w_halt_push = 1'b0;
    assign w_halted    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= '0;
            r_epoch    <= 1'b0;
        end else begin
            if (i_jump) r_fetch_pc <= i_jump_addr;
            else if (w_issue) r_fetch_pc <= r_fetch_pc + 1'b1;
            r_epoch <= r_epoch ^ (i_jump | w_halt_push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_ep  <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_pipe_pc[i] <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_ep[0]  <= r_epoch;
            r_pipe_pc[0]  <= r_fetch_pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_ep[i]  <= r_pipe_ep[i-1];
                r_pipe_pc[i]  <= r_pipe_pc[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_en) w_state_next = StRun;
            StRun:   if (!i_en) w_state_next = (w_inflight != '0) ? StDrain : StIdle;
            StDrain: begin
                if (i_en) w_state_next = StRun;
                else if (w_inflight == '0) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_mem_rd   = w_issue;
        o_mem_addr = r_fetch_pc;
        o_fetch_pc = r_fetch_pc;
        o_busy     = (w_inflight != '0) | (w_q_count != '0);
    end

    fetch_queue #(
        .DEPTH  (QDEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (i_mem_q),
        .i_push_pc   (r_pipe_pc[MEM_LAT-1]),
        .i_pop       (w_pop),
        .i_flush     (i_jump),
        .o_count     (w_q_count),
        .o_valid     (o_inst_valid),
        .o_head_data (o_inst),
        .o_head_pc   (o_inst_pc)
    );

endmodule
